// File: rtl/full_adder_bist.sv
// rtl/full_adder_bist.sv - BIST controller that applies all eight vectors to a 1-bit full adder and grades its responses
// Optional feature macro: FULL_ADDER_BIST_STOP_ON_FAIL_EN (first mismatch ends the run)
module full_adder_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [2:0]       dut_inputs,
    input  logic [1:0]       dut_outputs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       fail_vector
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Settle counter value on which the held vector is graded
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           r_state;
    logic [2:0]       r_vec;
    logic [7:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [2:0]       r_fail_vector;

    logic             w_settled;
    logic [1:0]       w_expected;
    logic             w_mismatch;
    logic             w_first_fail;
    logic [ERR_W-1:0] w_err_next;
    logic             w_stop_now;

    // Grade the current vector against the arithmetic sum of its three bits
    always_comb begin
        w_settled    = (r_cnt == SETTLE_LAST);
        w_expected   = {1'b0, r_vec[2]} + {1'b0, r_vec[1]} + {1'b0, r_vec[0]};
        w_mismatch   = (dut_outputs != w_expected);
        // The counter saturates and never wraps, so zero means no failure seen yet
        w_first_fail = w_mismatch && (r_err == '0);
        w_err_next   = r_err;
        if (w_mismatch && (r_err != ERR_MAX)) begin
            w_err_next = r_err + ERR_W'(1);
        end
    end

`ifdef FULL_ADDER_BIST_STOP_ON_FAIL_EN
    // A mismatch ends the run; the vector counter is left on the failing vector
    assign w_stop_now = w_mismatch;
`else
    assign w_stop_now = 1'b0;
`endif

    // Control FSM with all results held in registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_vec         <= 3'd0;
            r_cnt         <= 8'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err         <= '0;
            r_fail_vector <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_RUN;
                        r_vec         <= 3'd0;
                        r_cnt         <= 8'd0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_err         <= '0;
                        r_fail_vector <= 3'd0;
                    end
                end
                ST_RUN: begin
                    if (w_settled) begin
                        r_cnt <= 8'd0;
                        r_err <= w_err_next;
                        if (w_first_fail) begin
                            r_fail_vector <= r_vec;
                        end
                        if (w_stop_now || (r_vec == 3'd7)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_vec <= r_vec + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dut_inputs  = r_vec;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign err_count   = r_err;
    assign fail_vector = r_fail_vector;

endmodule
